// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO read-drain stage and neighbouring stream stages.
package fifo_stream_reader_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int FIFO_RD_LATENCY = 1;

    // Skid buffer geometry: one entry per cycle of read latency plus the
    // word being presented, plus one so a full buffer can still take a capture.
    localparam int BUF_DEPTH = 3;
    localparam int PTR_W     = 2;
    localparam int OCC_W     = 2;

    // Stream bundle control bits: valid, ready, last.
    localparam int STRM_CTRL_W = 3;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream bundle with packet framing marker.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, m_data, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Three-entry circular buffer: push at tail, pop at head, head word always visible.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic [DATA_WIDTH-1:0] head_data
);
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head, tail;

    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
            // Modular add/sub keeps push+pop at occ=3 correct.
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains sync_fifo into a framed valid/ready stream, hiding the FIFO's read latency.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int PKT_LEN       = 8,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]    fifo_data,
    fifo_stream_reader_if.master     m,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count
);
    localparam int               BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic              inflight;
    logic [OCC_W-1:0]  occ;
    logic [2:0]        occ_sum;
    logic [BEAT_W-1:0] beat;
    logic              pop;

    stream_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (m.m_data)
    );

    // Reserve a slot for every outstanding read so a capture can never overflow.
    assign occ_sum    = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en = !reset && !fifo_empty && (occ_sum < 3'd3);

    assign m.m_valid = (occ != '0);
    assign m.m_last  = m.m_valid && (beat == LAST_BEAT);
    assign pop       = m.m_valid && m.m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight  <= 1'b0;
            beat      <= '0;
            pkt_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                if (m.m_last) begin
                    beat      <= '0;
                    pkt_count <= pkt_count + PKT_CNT_WIDTH'(1);
                end else begin
                    beat <= beat + BEAT_W'(1);
                end
            end
        end
    end

    ap_no_overflow: assert property (@(posedge clk) disable iff (reset) occ_sum <= 3'd3);
    ap_no_empty_read: assert property (@(posedge clk) !(fifo_rd_en && fifo_empty));

endmodule
